enemy_arena: RTL
================

ENEMY_ARENA -- requirements
Module: enemy_arena

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- BOX_X 256: arena left edge, px; BOX_Y 256: arena top edge, px
- BOX_W 128 / BOX_H 128: arena outer width / height, px
- BORDER 16: border thickness, px
- BAR_T 8: hazard bar thickness, px
- FRAMES_PER_TURN 180: frames per attack phase, 1..1023
- NUM_TURNS 4: distinct patterns, 1..16
- ATTACK_STATE 4'b1000: state_in code that starts an attack
- TICK_H 0 / TICK_V 768: hcount/vcount point that marks a frame tick
- BORDER_COLOR 12'hFFF / BAR_COLOR 12'hF00: 12-bit RGB colours
REQ-002 Ports (name, direction, width, meaning):
- clk in 1: clock
- rst in 1: reset, synchronous, active-high
- hcount_in in 11: pixel x
- vcount_in in 10: pixel y
- state_in in 4: game state
- turn_in in 4: turn number
- rotate_in in 2: bar orientation from camera
- busy_out out 1: attack phase active
- finished_out out 1: one-cycle completion pulse
- pixel_out out 12: colour
- in_sprite_out out 1: pixel_out is non-transparent

Function
REQ-003 FSM states: IDLE, ACTIVE, DONE, HOLD.
REQ-004 IDLE -> ACTIVE when state_in==ATTACK_STATE; on entry:
- latch pattern = turn_in mod NUM_TURNS
- load frame_cnt = FRAMES_PER_TURN
- clear bar offset to 0
REQ-005 Frame tick: one-cycle condition, hcount_in==TICK_H && vcount_in==TICK_V.
REQ-006 ACTIVE, per tick: frame_cnt decrements by 1; on the tick taking frame_cnt to 0, next state is DONE.
REQ-007 DONE lasts exactly one cycle: finished_out=1, then HOLD.
REQ-008 HOLD -> IDLE only once state_in!=ATTACK_STATE; no retrigger while state_in is held.
REQ-009 ACTIVE with state_in!=ATTACK_STATE: abort to IDLE next cycle, no finished_out pulse; abort beats a simultaneous final tick.
REQ-010 busy_out=1 exactly in ACTIVE; finished_out=1 exactly in DONE; both registered.
REQ-011 Bar motion:
- per tick in ACTIVE: offset += speed, speed = pattern+1 px
- LIMIT = inner dimension - BAR_T, inner = BOX_W-2*BORDER (vertical bar) or BOX_H-2*BORDER (horizontal bar)
- if offset+speed >= LIMIT: offset = offset+speed-LIMIT (wrap); offset always < LIMIT
REQ-012 rotate_in is sampled on each tick; orientation change applies from the next tick:
- 0: horizontal bar, top+offset
- 1: vertical bar, left+offset
- 2: horizontal bar, bottom-BAR_T-offset
- 3: vertical bar, right-BAR_T-offset
Offsets are relative to the inner box.
REQ-013 Border region: inside outer box and not inside inner box.
REQ-014 Pixel priority, for ACTIVE and HOLD only: border -> BORDER_COLOR; else bar -> BAR_COLOR; else 0. pixel_out=0 in IDLE and DONE.
REQ-015 pixel_out and in_sprite_out are registered, 1-cycle latency from hcount_in/vcount_in; in_sprite_out = (pixel source is border or bar).
REQ-016 Coordinate compares use 12-bit unsigned math; no overflow at hcount_in=2047.

Reset
REQ-017 rst (sync, any state, including mid-ACTIVE) forces:
- IDLE
- busy_out=0, finished_out=0, pixel_out=0, in_sprite_out=0
- frame_cnt=0, offset=0, pattern=0, orientation=0

Configuration
REQ-018 ENEMY_ARENA_FLASH_EN defined:
- in ACTIVE, while frame_cnt<=32, border colour is BORDER_COLOR when frame_cnt[2]==0, else 0 (in_sprite_out still 1)
- HOLD: steady BORDER_COLOR
Undefined: border always steady BORDER_COLOR, no flash logic.

Verification
REQ-019 FRAMES_PER_TURN=3, state_in=8 held, 3 ticks:
- busy_out=1 one cycle after assertion
- finished_out=1 for exactly one cycle after the 3rd tick
- busy_out=0 from then; no restart until state_in leaves 8 and returns
REQ-020 turn_in=5, NUM_TURNS=4, rotate_in=0, defaults, after 2 ticks:
- pixel (x=300, y=276..279) = 12'hF00 (offset 4)
- x=260, y=300 = 12'hFFF, one cycle late
REQ-021 Wrap: LIMIT=88, speed=4, offset 86 + tick -> offset 2.
REQ-022 state_in drops mid-ACTIVE on the final tick -> IDLE, finished_out stays 0; rst asserted mid-ACTIVE -> all outputs 0 next cycle.
REQ-023 With ENEMY_ARENA_FLASH_EN, frame_cnt=28:
- border pixel = 0, in_sprite_out=1
- at frame_cnt=24, border pixel = 12'hFFF
Without the macro, border pixel = 12'hFFF at both.

Source files
------------

// File: rtl/enemy_arena.sv
// Attack-phase arena: border box plus a moving hazard bar, timed by frame ticks (optional ENEMY_ARENA_FLASH_EN border flash).
// Latency: pixel_out/in_sprite_out 1 cycle after hcount_in/vcount_in; busy_out/finished_out registered with the FSM.
// Backpressure: none, free-running pixel stream.
module enemy_arena #(
    parameter int          BOX_X           = 256,
    parameter int          BOX_Y           = 256,
    parameter int          BOX_W           = 128,
    parameter int          BOX_H           = 128,
    parameter int          BORDER          = 16,
    parameter int          BAR_T           = 8,
    parameter int          FRAMES_PER_TURN = 180,
    parameter int          NUM_TURNS       = 4,
    parameter logic [3:0]  ATTACK_STATE    = 4'b1000,
    parameter int          TICK_H          = 0,
    parameter int          TICK_V          = 768,
    parameter logic [11:0] BORDER_COLOR    = 12'hFFF,
    parameter logic [11:0] BAR_COLOR       = 12'hF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [3:0]  state_in,
    input  logic [3:0]  turn_in,
    input  logic [1:0]  rotate_in,
    output logic        busy_out,
    output logic        finished_out,
    output logic [11:0] pixel_out,
    output logic        in_sprite_out
);

    typedef logic [11:0] coord_t;
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE, HOLD} state_t;

    localparam coord_t OUT_X0  = coord_t'(BOX_X);
    localparam coord_t OUT_X1  = coord_t'(BOX_X + BOX_W);
    localparam coord_t OUT_Y0  = coord_t'(BOX_Y);
    localparam coord_t OUT_Y1  = coord_t'(BOX_Y + BOX_H);
    localparam coord_t IN_X0   = coord_t'(BOX_X + BORDER);
    localparam coord_t IN_X1   = coord_t'(BOX_X + BOX_W - BORDER);
    localparam coord_t IN_Y0   = coord_t'(BOX_Y + BORDER);
    localparam coord_t IN_Y1   = coord_t'(BOX_Y + BOX_H - BORDER);
    localparam coord_t BAR_W   = coord_t'(BAR_T);
    localparam coord_t LIMIT_H = coord_t'(BOX_H - 2*BORDER - BAR_T);
    localparam coord_t LIMIT_V = coord_t'(BOX_W - 2*BORDER - BAR_T);

    state_t      state;
    logic [9:0]  frame_cnt;
    coord_t      offset;
    logic [3:0]  pattern;
    logic [1:0]  orient;

    logic        tick;
    logic        attack;
    coord_t      speed;
    coord_t      limit;
    coord_t      sum;
    coord_t      offset_nxt;

    assign tick   = (hcount_in == 11'(TICK_H)) && (vcount_in == 10'(TICK_V));
    assign attack = (state_in == ATTACK_STATE);

    // Limit follows the orientation being latched on this tick so the offset stays in range for what is drawn.
    always_comb begin
        speed      = coord_t'(pattern) + 12'd1;
        limit      = rotate_in[0] ? LIMIT_V : LIMIT_H;
        sum        = offset + speed;
        offset_nxt = sum;
        if (sum >= limit) begin
            offset_nxt = sum - limit;
            if (offset_nxt >= limit)
                offset_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy_out     <= 1'b0;
            finished_out <= 1'b0;
            frame_cnt    <= '0;
            offset       <= '0;
            pattern      <= '0;
            orient       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    finished_out <= 1'b0;
                    if (attack) begin
                        state     <= ACTIVE;
                        busy_out  <= 1'b1;
                        pattern   <= 4'(int'(turn_in) % NUM_TURNS);
                        frame_cnt <= 10'(FRAMES_PER_TURN);
                        offset    <= '0;
                    end
                end
                ACTIVE: begin
                    if (!attack) begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end else if (tick) begin
                        frame_cnt <= frame_cnt - 10'd1;
                        offset    <= offset_nxt;
                        orient    <= rotate_in;
                        if (frame_cnt <= 10'd1) begin
                            state        <= DONE;
                            busy_out     <= 1'b0;
                            finished_out <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state        <= HOLD;
                    finished_out <= 1'b0;
                end
                HOLD: begin
                    if (!attack)
                        state <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    busy_out     <= 1'b0;
                    finished_out <= 1'b0;
                end
            endcase
        end
    end

    coord_t      px;
    coord_t      py;
    logic        in_outer;
    logic        in_inner;
    logic        bar_hit;
    logic        show;
    logic [11:0] border_col;
    logic [11:0] pix_nxt;
    logic        spr_nxt;

    always_comb begin
        px       = {1'b0, hcount_in};
        py       = {2'b0, vcount_in};
        in_outer = (px >= OUT_X0) && (px < OUT_X1) && (py >= OUT_Y0) && (py < OUT_Y1);
        in_inner = (px >= IN_X0) && (px < IN_X1) && (py >= IN_Y0) && (py < IN_Y1);
        bar_hit  = 1'b0;
        case (orient)
            2'd0:    bar_hit = (py >= IN_Y0 + offset) && (py < IN_Y0 + offset + BAR_W);
            2'd1:    bar_hit = (px >= IN_X0 + offset) && (px < IN_X0 + offset + BAR_W);
            2'd2:    bar_hit = (py >= IN_Y1 - BAR_W - offset) && (py < IN_Y1 - offset);
            default: bar_hit = (px >= IN_X1 - BAR_W - offset) && (px < IN_X1 - offset);
        endcase
        bar_hit = bar_hit && in_inner;
        show    = (state == ACTIVE) || (state == HOLD);

`ifdef ENEMY_ARENA_FLASH_EN
        // Blink during the last 32 frames; the border still counts as sprite while dark.
        if ((state == ACTIVE) && (frame_cnt <= 10'd32) && frame_cnt[2])
            border_col = 12'h000;
        else
            border_col = BORDER_COLOR;
`else
        border_col = BORDER_COLOR;
`endif

        pix_nxt = 12'h000;
        spr_nxt = 1'b0;
        if (show && in_outer && !in_inner) begin
            pix_nxt = border_col;
            spr_nxt = 1'b1;
        end else if (show && bar_hit) begin
            pix_nxt = BAR_COLOR;
            spr_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_out     <= 12'h000;
            in_sprite_out <= 1'b0;
        end else begin
            pixel_out     <= pix_nxt;
            in_sprite_out <= spr_nxt;
        end
    end

endmodule
